pipeline_stage_ctrl: RTL and testbench
======================================

# pipeline_stage_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It drives the enable and flush (bubble-insert) inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazards in a fixed priority: multi-cycle data-memory waits, taken branches/jumps resolved in EX, and load-use dependencies. A watchdog halts the pipeline when the data memory fails to acknowledge in time.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before a timeout error (range 2..255).

Ports:
- Clk  in  1  pipeline clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Rs_ID, Rt_ID  in  5 each  source register numbers of the instruction in ID.
- UsesRt_ID  in  1  instruction in ID reads Rt.
- MemRead_EX  in  1  instruction in EX is a load.
- WriteReg_EX  in  5  destination register of the instruction in EX.
- BranchTaken_EX  in  1  branch/jump in EX redirects the PC.
- MemReq_MEM  in  1  load/store in MEM is accessing data memory.
- MemAck  in  1  data memory completes the access this cycle.
- ErrClr  in  1  software/debug clear of the timeout halt.
- PCWrite  out  1  PC load enable.
- IFID_En, IDEX_En, EXMEM_En, MEMWB_En  out  1 each  stage register load enables.
- IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  load a bubble (all zeros) instead of data. Flush=1 always comes with the matching En=1.
- MemErr  out  1  timeout halt active.
- State  out  2  current FSM state, for debug.

## Operation
- States: RUN=0, MEM_WAIT=1, ERR=2. The state and a 8-bit wait counter are registered. All other outputs are combinational (Mealy).
- **RUN**, rules evaluated in priority order:
  1. If MemReq_MEM=1 and MemAck=0: PCWrite, IFID/IDEX/EXMEM_En are 0, MEMWB_Flush=1, counter←0, next state is MEM_WAIT.
  2. Else if BranchTaken_EX=1: everything is enabled, and IFID_Flush=IDEX_Flush=1.
  3. Else if load-use: PCWrite=0, IFID_En=0, IDEX_Flush=1, and EXMEM/MEMWB are enabled. Load-use is MemRead_EX & (WriteReg_EX≠0) & (WriteReg_EX==Rs_ID | (UsesRt_ID & WriteReg_EX==Rt_ID)).
  4. Else: everything is enabled with no flush.
- A request and MemAck in the same cycle is a single-cycle access. No stall occurs, and rules 2–4 apply.
- **MEM_WAIT**:
  - While MemAck=0: outputs are the same as rule 1 (frozen pipeline, bubble into WB) and the counter increments.
  - On MemAck=1: rules 2–4 apply to the held EX/ID contents and the next state is RUN.
  - If MemAck=0 while counter==MEM_TIMEOUT−1: the next state is ERR.
  - If MemAck and timeout occur in the same cycle, the ack wins.
- **ERR**:
  - MemErr=1. All enables are 0 and all flushes are 0, so the pipeline is halted.
  - On ErrClr=1: EXMEM_Flush=1 (drops the faulting access), MEMWB_Flush=1, all other enables are 0, and the next state is RUN.
  - ErrClr has no effect in other states.
- BranchTaken_EX and load-use are ignored in ERR and in stalled MEM_WAIT cycles.

## Timing
- While Reset=0:
  - State=RUN, counter=0, MemErr=0.
  - PCWrite=0 and all *_En=0.
  - All *_Flush=0 except MEMWB_Flush=0.
  - Stats counters are 0.
- The first rising edge after Reset deasserts applies normal RUN rules.
- Decision latency is 0 cycles: outputs respond in the same cycle as their inputs.
- Stall length: a load-use stall is exactly 1 cycle. A memory stall lasts N cycles, where N is the number of cycles MemAck stays low after the request.
- Timeout: with MemAck stuck at 0, MEM_WAIT lasts MEM_TIMEOUT cycles, then MemErr rises.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately (asynchronously). The pending access is abandoned.

## Configuration
- PIPE_CTRL_STATS_EN defined: the block adds two output ports.
  - StallCount [15:0]: counts cycles with PCWrite=0 in RUN or MEM_WAIT.
  - FlushCount [15:0]: counts cycles with IFID_Flush=1.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: these ports and their logic are absent. Control behaviour is identical either way.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state encodings (ST_RUN, ST_MEM_WAIT, ST_ERR);
  - the MEM_TIMEOUT default;
  - the REG_ZERO=5'd0 constant.
- Sub-module load_use_detect: purely combinational. It takes Rs_ID, Rt_ID, UsesRt_ID, MemRead_EX and WriteReg_EX, and outputs LoadUse.
- The FSM, wait counter and output decode live in the top module.

## Test plan
- Load-use: MemRead_EX=1, WriteReg_EX=8, Rs_ID=8 → one cycle with PCWrite=0, IFID_En=0, IDEX_Flush=1. With WriteReg_EX=0 → no stall.
- Branch: BranchTaken_EX=1 → IFID_Flush=IDEX_Flush=1 and PCWrite=1 for exactly one cycle. Branch plus load-use together → the branch flush wins.
- Memory wait: MemReq_MEM=1, MemAck low for 3 cycles then high → State=1 for 3 cycles with MEMWB_Flush=1, then all enables are 1 and State=0.
- Timeout: MEM_TIMEOUT=4, MemAck stuck at 0 → after 4 MEM_WAIT cycles MemErr=1 and State=2. ErrClr → EXMEM_Flush=1, then RUN.
- Ack on the timeout cycle: MemAck rises on wait cycle MEM_TIMEOUT−1 → return to RUN and MemErr stays 0.
- Reset mid-wait: Reset low during MEM_WAIT → State=0 immediately and PCWrite=0. After release, normal RUN resumes. With PIPE_CTRL_STATS_EN, StallCount=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encodings, the default memory timeout and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;
  localparam logic [4:0]  REG_ZERO            = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// feeds a source operand of the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       UsesRt_ID,
  input  logic       MemRead_EX,
  input  logic [4:0] WriteReg_EX,
  output logic       LoadUse
);

  always_comb begin
    LoadUse = MemRead_EX && (WriteReg_EX != REG_ZERO) &&
              ((WriteReg_EX == Rs_ID) || (UsesRt_ID && (WriteReg_EX == Rt_ID)));
  end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline (memory wait,
// branch flush, load-use stall, memory watchdog). Optional PIPE_CTRL_STATS_EN adds stall/flush counters.
module pipeline_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic       UsesRt_ID,
  input  logic       MemRead_EX,
  input  logic [4:0] WriteReg_EX,
  input  logic       BranchTaken_EX,
  input  logic       MemReq_MEM,
  input  logic       MemAck,
  input  logic       ErrClr,
  output logic       PCWrite,
  output logic       IFID_En,
  output logic       IDEX_En,
  output logic       EXMEM_En,
  output logic       MEMWB_En,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       MEMWB_Flush,
  output logic       MemErr,
  output logic [1:0] State
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
`endif
);

  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

  state_t     state, nextState;
  logic [7:0] waitCnt, waitNext;
  logic       loadUse, freeze, decode;

  load_use_detect uLoadUse (
    .Rs_ID       (Rs_ID),
    .Rt_ID       (Rt_ID),
    .UsesRt_ID   (UsesRt_ID),
    .MemRead_EX  (MemRead_EX),
    .WriteReg_EX (WriteReg_EX),
    .LoadUse     (loadUse)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= waitNext;
    end
  end

  always_comb begin
    nextState   = state;
    waitNext    = waitCnt;
    freeze      = 1'b0;
    decode      = 1'b0;
    PCWrite     = 1'b0;
    IFID_En     = 1'b0;
    IDEX_En     = 1'b0;
    EXMEM_En    = 1'b0;
    MEMWB_En    = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MEMWB_Flush = 1'b0;
    MemErr      = 1'b0;

    case (state)
      ST_RUN: begin
        if (MemReq_MEM && !MemAck) begin
          freeze    = 1'b1;
          nextState = ST_MEM_WAIT;
          waitNext  = '0;
        end else begin
          decode = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // An ack on the last allowed wait cycle still returns to RUN.
        if (!MemAck) begin
          freeze = 1'b1;
          if (waitCnt == LastWait) nextState = ST_ERR;
          else                     waitNext  = waitCnt + 8'd1;
        end else begin
          decode    = 1'b1;
          nextState = ST_RUN;
        end
      end
      ST_ERR: begin
        MemErr = 1'b1;
        if (ErrClr) begin
          EXMEM_En    = 1'b1;
          EXMEM_Flush = 1'b1;
          MEMWB_En    = 1'b1;
          MEMWB_Flush = 1'b1;
          nextState   = ST_RUN;
        end
      end
      default: nextState = ST_RUN;
    endcase

    // State is forced to RUN during reset, so only the RUN decode needs masking.
    if (!Reset) begin
      freeze = 1'b0;
      decode = 1'b0;
    end

    if (freeze) begin
      MEMWB_En    = 1'b1;
      MEMWB_Flush = 1'b1;
    end

    if (decode) begin
      PCWrite  = 1'b1;
      IFID_En  = 1'b1;
      IDEX_En  = 1'b1;
      EXMEM_En = 1'b1;
      MEMWB_En = 1'b1;
      if (BranchTaken_EX) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (loadUse) begin
        PCWrite    = 1'b0;
        IFID_En    = 1'b0;
        IDEX_Flush = 1'b1;
      end
    end
  end

  assign State = state;

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (state != ST_ERR) && (StallCount != '1))
        StallCount <= StallCount + 16'd1;
      if (IFID_Flush && (FlushCount != '1))
        FlushCount <= FlushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Self-checking bench for pipeline_stage_ctrl: directed hazard scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_pipeline_stage_ctrl;

  localparam int unsigned TMO = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] Rs_ID, Rt_ID, WriteReg_EX;
  logic       UsesRt_ID, MemRead_EX, BranchTaken_EX, MemReq_MEM, MemAck, ErrClr;
  logic       PCWrite, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic       IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, MemErr;
  logic [1:0] State;
`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] StallCount, FlushCount;
`endif

  int nChecks = 0;
  int nFails  = 0;

  pipeline_stage_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID),
    .MemRead_EX(MemRead_EX), .WriteReg_EX(WriteReg_EX),
    .BranchTaken_EX(BranchTaken_EX), .MemReq_MEM(MemReq_MEM),
    .MemAck(MemAck), .ErrClr(ErrClr),
    .PCWrite(PCWrite), .IFID_En(IFID_En), .IDEX_En(IDEX_En),
    .EXMEM_En(EXMEM_En), .MEMWB_En(MEMWB_En),
    .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Flush(EXMEM_Flush), .MEMWB_Flush(MEMWB_Flush),
    .MemErr(MemErr), .State(State)
`ifdef PIPE_CTRL_STATS_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model phase: 0 running, 1 waiting on memory, 2 halted on timeout.
  // stalledWaits counts how many frozen wait cycles have already elapsed.
  int          mPhase = 0;
  int          stalledWaits = 0;
  int unsigned mStalls = 0, mFlushes = 0;

  // Output vector: {PCWrite, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
  //                 IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, MemErr}
  function automatic void model(output logic [9:0] o, output int nPhase, output int nWaits);
    logic lu;
    logic [9:0] normal;
    lu = MemRead_EX && (WriteReg_EX != 5'd0) &&
         ((WriteReg_EX == Rs_ID) || (UsesRt_ID && (WriteReg_EX == Rt_ID)));
    if (BranchTaken_EX) normal = 10'b11111_1100_0;
    else if (lu)        normal = 10'b00111_0100_0;
    else                normal = 10'b11111_0000_0;
    nPhase = mPhase;
    nWaits = stalledWaits;
    o = 10'b0;
    if (!Reset) begin
      nPhase = 0;
      nWaits = 0;
    end else if (mPhase == 0) begin
      if (MemReq_MEM && !MemAck) begin
        o = 10'b00001_0001_0;
        nPhase = 1;
        nWaits = 0;
      end else o = normal;
    end else if (mPhase == 1) begin
      if (MemAck) begin
        o = normal;
        nPhase = 0;
      end else begin
        o = 10'b00001_0001_0;
        nWaits = stalledWaits + 1;
        if (nWaits == int'(TMO)) nPhase = 2;
      end
    end else begin
      o = ErrClr ? 10'b00011_0011_1 : 10'b00000_0000_1;
      if (ErrClr) nPhase = 0;
    end
  endfunction

  always @(posedge Clk or negedge Reset) begin
    logic [9:0] o;
    int np, nw;
    if (!Reset) begin
      mPhase = 0; stalledWaits = 0; mStalls = 0; mFlushes = 0;
    end else begin
      model(o, np, nw);
      if (!o[9] && mPhase != 2 && mStalls < 65535) mStalls++;
      if (o[4] && mFlushes < 65535) mFlushes++;
      mPhase = np;
      stalledWaits = nw;
    end
  end

  // Single compare process, mid-cycle on the falling edge.
  always @(negedge Clk) begin
    logic [9:0] e;
    int np, nw;
    model(e, np, nw);
    chk("PCWrite",     {15'd0, PCWrite},     {15'd0, e[9]});
    chk("IFID_En",     {15'd0, IFID_En},     {15'd0, e[8]});
    chk("IDEX_En",     {15'd0, IDEX_En},     {15'd0, e[7]});
    chk("EXMEM_En",    {15'd0, EXMEM_En},    {15'd0, e[6]});
    chk("MEMWB_En",    {15'd0, MEMWB_En},    {15'd0, e[5]});
    chk("IFID_Flush",  {15'd0, IFID_Flush},  {15'd0, e[4]});
    chk("IDEX_Flush",  {15'd0, IDEX_Flush},  {15'd0, e[3]});
    chk("EXMEM_Flush", {15'd0, EXMEM_Flush}, {15'd0, e[2]});
    chk("MEMWB_Flush", {15'd0, MEMWB_Flush}, {15'd0, e[1]});
    chk("MemErr",      {15'd0, MemErr},      {15'd0, e[0]});
    chk("State",       {14'd0, State},       16'(mPhase));
`ifdef PIPE_CTRL_STATS_EN
    chk("StallCount",  StallCount, 16'(mStalls));
    chk("FlushCount",  FlushCount, 16'(mFlushes));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Rs_ID = 5'd1; Rt_ID = 5'd2; UsesRt_ID = 1'b0; MemRead_EX = 1'b0;
    WriteReg_EX = 5'd0; BranchTaken_EX = 1'b0; MemReq_MEM = 1'b0;
    MemAck = 1'b0; ErrClr = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    idle();
    nxt();
    #2;
    chk("rst_State",   {14'd0, State}, 16'd0);
    chk("rst_PCWrite", {15'd0, PCWrite}, 16'd0);
    chk("rst_MEMWB_Flush", {15'd0, MEMWB_Flush}, 16'd0);
    chk("rst_MemErr",  {15'd0, MemErr}, 16'd0);
    nxt();
    Reset = 1'b1;

    // Load-use on Rs: one-cycle stall.
    MemRead_EX = 1'b1; WriteReg_EX = 5'd8; Rs_ID = 5'd8;
    #2;
    chk("lu_PCWrite", {15'd0, PCWrite}, 16'd0);
    chk("lu_IFID_En", {15'd0, IFID_En}, 16'd0);
    chk("lu_IDEX_Flush", {15'd0, IDEX_Flush}, 16'd1);
    chk("lu_EXMEM_En", {15'd0, EXMEM_En}, 16'd1);
    nxt();
    MemRead_EX = 1'b0;
    #2 chk("lu_after_PCWrite", {15'd0, PCWrite}, 16'd1);
    nxt();

    // Load into $zero never stalls.
    MemRead_EX = 1'b1; WriteReg_EX = 5'd0; Rs_ID = 5'd0;
    #2 chk("lu_zero_PCWrite", {15'd0, PCWrite}, 16'd1);
    nxt();

    // Branch together with load-use: branch flush wins.
    WriteReg_EX = 5'd9; Rt_ID = 5'd9; UsesRt_ID = 1'b1; BranchTaken_EX = 1'b1;
    #2;
    chk("br_PCWrite", {15'd0, PCWrite}, 16'd1);
    chk("br_IFID_Flush", {15'd0, IFID_Flush}, 16'd1);
    chk("br_IDEX_Flush", {15'd0, IDEX_Flush}, 16'd1);
    nxt();
    idle();

    // Memory wait: ack low for 3 cycles, then high.
    MemReq_MEM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mw_MEMWB_Flush", {15'd0, MEMWB_Flush}, 16'd1);
      chk("mw_PCWrite", {15'd0, PCWrite}, 16'd0);
      nxt();
    end
    MemAck = 1'b1;
    #2;
    chk("mw_ack_State", {14'd0, State}, 16'd1);
    chk("mw_ack_PCWrite", {15'd0, PCWrite}, 16'd1);
    nxt();
    idle();
    #2 chk("mw_done_State", {14'd0, State}, 16'd0);
    nxt();

    // Timeout: TMO frozen wait cycles, then halt; ErrClr recovers.
    MemReq_MEM = 1'b1;
    nxt();
    for (int i = 0; i < int'(TMO); i++) begin
      #2 chk("to_wait_State", {14'd0, State}, 16'd1);
      nxt();
    end
    #2;
    chk("to_State", {14'd0, State}, 16'd2);
    chk("to_MemErr", {15'd0, MemErr}, 16'd1);
    chk("to_MEMWB_En", {15'd0, MEMWB_En}, 16'd0);
    nxt();
    ErrClr = 1'b1;
    #2;
    chk("clr_EXMEM_Flush", {15'd0, EXMEM_Flush}, 16'd1);
    chk("clr_PCWrite", {15'd0, PCWrite}, 16'd0);
    nxt();
    idle();
    #2 chk("clr_State", {14'd0, State}, 16'd0);
    nxt();

    // Ack on the last permitted wait cycle.
    MemReq_MEM = 1'b1;
    for (int i = 0; i < int'(TMO); i++) nxt();
    MemAck = 1'b1;
    #2 chk("lastack_State", {14'd0, State}, 16'd1);
    nxt();
    idle();
    #2;
    chk("lastack_after_State", {14'd0, State}, 16'd0);
    chk("lastack_MemErr", {15'd0, MemErr}, 16'd0);
    nxt();

    // Reset mid-wait.
    MemReq_MEM = 1'b1;
    nxt();
    #2 chk("rw_wait_State", {14'd0, State}, 16'd1);
    Reset = 1'b0;
    #1;
    chk("rw_State", {14'd0, State}, 16'd0);
    chk("rw_PCWrite", {15'd0, PCWrite}, 16'd0);
`ifdef PIPE_CTRL_STATS_EN
    chk("rw_StallCount", StallCount, 16'd0);
`endif
    nxt();
    Reset = 1'b1;
    idle();
    #2 chk("rw_resume_PCWrite", {15'd0, PCWrite}, 16'd1);
    nxt();

    // Randomized traffic, alternating high- and low-ack phases.
    for (int i = 0; i < 3000; i++) begin
      int ackDen;
      ackDen = ((i / 100) % 2 == 0) ? 2 : 10;
      Rs_ID          = 5'($urandom_range(0, 3));
      Rt_ID          = 5'($urandom_range(0, 3));
      WriteReg_EX    = 5'($urandom_range(0, 3));
      UsesRt_ID      = 1'($urandom_range(0, 1));
      MemRead_EX     = 1'($urandom_range(0, 1));
      BranchTaken_EX = ($urandom_range(0, 4) == 0);
      MemReq_MEM     = ($urandom_range(0, 2) == 0);
      MemAck         = ($urandom_range(0, ackDen - 1) == 0);
      ErrClr         = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b0;
        nxt();
        Reset = 1'b1;
      end else begin
        nxt();
      end
    end

    idle();
    nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
